conv_x_stream_tx: RTL

//  Transmit end of the conv x-input stream: buffers one frame of SIZE signed samples and

---
 rtl/conv_stream_pkg.sv | 18 +
 rtl/x_frame_buffer.sv | 27 ++
 rtl/conv_x_stream_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conv_stream_pkg.sv
// Shared types and default sizes for the conv x-stream transmit path.
package conv_stream_pkg;

    localparam int CONV_T       = 8;
    localparam int CONV_SIZE    = 8;
    localparam int CONV_LOGSIZE = 3;
    localparam int CONV_CNTW    = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_FILL,
        TX_SEND,
        TX_FINISH
    } tx_state_t;

    typedef logic signed [CONV_T-1:0] sample_t;

endpackage

// File: rtl/x_frame_buffer.sv
// One-frame sample store: host writes while idle, transmitter reads with 1-cycle latency.
module x_frame_buffer #(
    parameter int T       = 8,
    parameter int SIZE    = 8,
    parameter int LOGSIZE = 3
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [T-1:0]       wr_data,
    input  logic               rd_en,
    input  logic [LOGSIZE-1:0] rd_addr,
    output logic [T-1:0]       rd_data
);

    logic [T-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_x_stream_tx.sv
// Replays a host-loaded frame num_frames times on a valid/ready master port.
// Valid/ready: a sample moves on a posedge with m_valid_x & m_ready_x; valid never waits on ready.
module conv_x_stream_tx
    import conv_stream_pkg::*;
#(
    parameter int T       = CONV_T,
    parameter int SIZE    = CONV_SIZE,
    parameter int LOGSIZE = CONV_LOGSIZE,
    parameter int CNTW    = CONV_CNTW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [T-1:0]       wr_data,
    input  logic               start,
    input  logic [CNTW-1:0]    num_frames,
    output logic               busy,
    output logic               done,
    output logic [T-1:0]       m_data_out_x,
    output logic               m_valid_x,
    input  logic               m_ready_x,
    output tx_state_t          dbg_state
);

    localparam logic [LOGSIZE-1:0] PTR_LAST = LOGSIZE'(SIZE - 1);

    tx_state_t          state;
    logic               busy_q;
    logic               done_q;
    logic [CNTW-1:0]    nf_q;
    logic [CNTW-1:0]    frame_cnt;
    logic [LOGSIZE-1:0] rd_ptr;
    logic               reads_done;
    logic               inflight;

    logic [T-1:0]       fifo_q [2];
    logic               wr_idx;
    logic               rd_idx;
    logic [1:0]         count;

    logic [T-1:0]       rd_data;
    logic               pop;
    logic               push;
    logic [2:0]         occ_next;
    logic               rd_issue;
    logic               last_issue;
    logic               last_pop;

    x_frame_buffer #(
        .T       (T),
        .SIZE    (SIZE),
        .LOGSIZE (LOGSIZE)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en & ~busy_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign pop  = (count != 2'd0) & m_ready_x;
    assign push = inflight;

    // Occupancy after this edge counting the read already in flight; a new read
    // is only launched if its data is certain to find a free slot.
    assign occ_next   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign rd_issue   = ((state == TX_FILL) || (state == TX_SEND)) && !reads_done
                        && (occ_next < 3'd2);
    assign last_issue = rd_issue && (rd_ptr == PTR_LAST)
                        && (frame_cnt == nf_q - CNTW'(1));
    assign last_pop   = pop && reads_done && !inflight && (count == 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= TX_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nf_q       <= '0;
            frame_cnt  <= '0;
            rd_ptr     <= '0;
            reads_done <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= rd_issue;
            if (rd_issue) begin
                if (rd_ptr == PTR_LAST) begin
                    rd_ptr    <= '0;
                    frame_cnt <= frame_cnt + CNTW'(1);
                end else begin
                    rd_ptr <= rd_ptr + LOGSIZE'(1);
                end
                if (last_issue) begin
                    reads_done <= 1'b1;
                end
            end
            case (state)
                TX_IDLE, TX_FINISH: begin
                    if (start) begin
                        nf_q       <= num_frames;
                        frame_cnt  <= '0;
                        rd_ptr     <= '0;
                        reads_done <= 1'b0;
                        if (num_frames == '0) begin
                            state  <= TX_FINISH;
                            done_q <= 1'b1;
                        end else begin
                            state  <= TX_FILL;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        state <= TX_IDLE;
                    end
                end
                TX_FILL: begin
                    state <= TX_SEND;
                end
                TX_SEND: begin
                    if (last_pop) begin
                        state  <= TX_FINISH;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-entry skid FIFO: RAM data lands here one cycle after its read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_idx    <= 1'b0;
            rd_idx    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_idx] <= rd_data;
                wr_idx         <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_valid_x    = (count != 2'd0);
    assign m_data_out_x = fifo_q[rd_idx];
    assign busy         = busy_q;
    assign done         = done_q;
    assign dbg_state    = state;

endmodule
